// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared mode encodings and step-tracker states for the Gray stream codec
package gray_pkg;

   localparam logic MODE_DECODE = 1'b0;
   localparam logic MODE_ENCODE = 1'b1;

   localparam logic [0:0] ST_NOPREV = 1'b0;
   localparam logic [0:0] ST_TRACK  = 1'b1;

endpackage

// File: rtl/gray_conv.sv
// rtl/gray_conv.sv - combinational Gray-to-binary / binary-to-Gray converter
module gray_conv
   import gray_pkg::*;
#(
   parameter int WIDTH = 3
) (
   input  logic             mode,
   input  logic [WIDTH-1:0] in_data,
   output logic [WIDTH-1:0] out_data
);

   logic [WIDTH-1:0] dec;

   // Each binary bit is the parity of all Gray bits at or above it.
   always_comb begin
      dec = '0;
      for (int i = 0; i < WIDTH; i++) begin
         dec[i] = ^(in_data >> i);
      end
   end

   assign out_data = (mode == MODE_ENCODE) ? (in_data ^ (in_data >> 1)) : dec;

endmodule

// File: rtl/gray_stream_codec.sv
// rtl/gray_stream_codec.sv - registered Gray codec stream stage with decode step checker
module gray_stream_codec
   import gray_pkg::*;
#(
   parameter int WIDTH = 3,
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mode,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             step_err,
   output logic             dir_up,
   output logic [ERR_W-1:0] err_count,
   input  logic             clear_err
);

   logic [0:0]       state;
   logic [WIDTH-1:0] prev_gray;
   logic [WIDTH-1:0] prev_bin;
   logic [WIDTH-1:0] prev_inc;
   logic [WIDTH-1:0] next_gray;
   logic [WIDTH-1:0] conv_data;
   logic [WIDTH-1:0] diff;
   logic             accept;
   logic             decoding;
   logic             dist_zero;
   logic             dist_one;
   logic             bad_step;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign decoding = (mode == MODE_DECODE);

   gray_conv #(.WIDTH(WIDTH)) u_data_conv (
      .mode     (mode),
      .in_data  (in_data),
      .out_data (conv_data)
   );

   // An upward step is one whose new Gray word equals the encoding of prev_bin+1 (wraps naturally).
   assign prev_inc = prev_bin + WIDTH'(1);

   gray_conv #(.WIDTH(WIDTH)) u_step_conv (
      .mode     (MODE_ENCODE),
      .in_data  (prev_inc),
      .out_data (next_gray)
   );

   assign diff      = in_data ^ prev_gray;
   assign dist_zero = (diff == '0);
   assign dist_one  = !dist_zero && ((diff & (diff - WIDTH'(1))) == '0);
   assign bad_step  = decoding && (state == ST_TRACK) && !dist_zero && !dist_one;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         step_err  <= 1'b0;
         dir_up    <= 1'b1;
         err_count <= '0;
         state     <= ST_NOPREV;
         prev_gray <= '0;
         prev_bin  <= '0;
      end else begin
         if (accept) begin
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         if (accept) begin
            out_data <= conv_data;
            step_err <= bad_step;
            if (decoding) begin
               state     <= ST_TRACK;
               prev_gray <= in_data;
               prev_bin  <= conv_data;
               if (state == ST_TRACK && dist_one) begin
                  dir_up <= (in_data == next_gray);
               end
            end else begin
               state <= ST_NOPREV;
            end
         end

         if (clear_err) begin
            err_count <= '0;
         end else if (accept && bad_step && !(&err_count)) begin
            err_count <= err_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_gray_stream_codec.sv
// tb/tb_gray_stream_codec.sv - directed self-checking bench for gray_stream_codec
module tb_gray_stream_codec;

   logic       clk = 1'b0;
   logic       reset;
   logic       mode;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] out_data;
   logic       step_err;
   logic       dir_up;
   logic [7:0] err_count;
   logic       clear_err;

   int checks = 0;
   int errors = 0;
   logic [2:0] mon_q[$];

   gray_stream_codec #(.WIDTH(3), .ERR_W(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .mode      (mode),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .step_err  (step_err),
      .dir_up    (dir_up),
      .err_count (err_count),
      .clear_err (clear_err)
   );

   always #5 clk = ~clk;

   // Output transfers seen at the falling edge complete on the following rising edge.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) mon_q.push_back(out_data);
   end

   task automatic send(input logic m, input logic [2:0] d);
      mode = m; in_data = d; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; mode = 1'b0; in_valid = 1'b0; in_data = 3'd0; out_ready = 1'b1; clear_err = 1'b0;
      #3;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (out_data !== 3'd0) begin errors++; $display("FAIL reset_out_data got %0d want 0", out_data); end
      checks++; if (step_err !== 1'b0) begin errors++; $display("FAIL reset_step_err got %b want 0", step_err); end
      checks++; if (dir_up !== 1'b1) begin errors++; $display("FAIL reset_dir_up got %b want 1", dir_up); end
      checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count got %0d want 0", err_count); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_decode_stream();
      logic [2:0] g[8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
      for (int i = 0; i < 8; i++) begin
         send(1'b0, g[i]);
         checks++; if (out_valid !== 1'b1 || out_data !== 3'(i)) begin errors++; $display("FAIL stream_data[%0d] got v=%b d=%0d want v=1 d=%0d", i, out_valid, out_data, i); end
         checks++; if (step_err !== 1'b0 || dir_up !== 1'b1) begin errors++; $display("FAIL stream_flags[%0d] got err=%b up=%b want err=0 up=1", i, step_err, dir_up); end
      end
   endtask

   task automatic test_wrap();
      send(1'b0, 3'b000);
      checks++; if (out_data !== 3'd0 || dir_up !== 1'b1 || step_err !== 1'b0) begin errors++; $display("FAIL wrap_up got d=%0d up=%b err=%b want d=0 up=1 err=0", out_data, dir_up, step_err); end
      send(1'b0, 3'b100);
      checks++; if (out_data !== 3'd7 || dir_up !== 1'b0 || step_err !== 1'b0) begin errors++; $display("FAIL wrap_down got d=%0d up=%b err=%b want d=7 up=0 err=0", out_data, dir_up, step_err); end
   endtask

   task automatic test_step_error();
      clear_err = 1'b1; @(posedge clk); #1 clear_err = 1'b0;
      send(1'b0, 3'b000);
      checks++; if (dir_up !== 1'b1 || step_err !== 1'b0) begin errors++; $display("FAIL err_pre got up=%b err=%b want up=1 err=0", dir_up, step_err); end
      send(1'b0, 3'b011);
      checks++; if (out_data !== 3'd2 || step_err !== 1'b1 || err_count !== 8'd1 || dir_up !== 1'b1) begin errors++; $display("FAIL err_first got d=%0d err=%b cnt=%0d up=%b want d=2 err=1 cnt=1 up=1", out_data, step_err, err_count, dir_up); end
      for (int k = 0; k < 254; k++) send(1'b0, (k % 2 == 0) ? 3'b000 : 3'b011);
      checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL err_reach_max got %0d want 255", err_count); end
      send(1'b0, 3'b000);
      checks++; if (err_count !== 8'd255 || step_err !== 1'b1) begin errors++; $display("FAIL err_saturate got cnt=%0d err=%b want cnt=255 err=1", err_count, step_err); end
      clear_err = 1'b1;
      send(1'b0, 3'b011);
      clear_err = 1'b0;
      checks++; if (err_count !== 8'd0 || step_err !== 1'b1) begin errors++; $display("FAIL clear_priority got cnt=%0d err=%b want cnt=0 err=1", err_count, step_err); end
   endtask

   task automatic test_encode();
      send(1'b1, 3'd5);
      checks++; if (out_data !== 3'b111 || step_err !== 1'b0) begin errors++; $display("FAIL enc_5 got d=%b err=%b want d=111 err=0", out_data, step_err); end
      out_ready = 1'b0; mode = 1'b0;
      @(posedge clk); #1;
      checks++; if (out_data !== 3'b111 || out_valid !== 1'b1) begin errors++; $display("FAIL enc_mode_switch_hold got d=%b v=%b want d=111 v=1", out_data, out_valid); end
      out_ready = 1'b1;
      send(1'b1, 3'd2);
      checks++; if (out_data !== 3'b011 || step_err !== 1'b0) begin errors++; $display("FAIL enc_2 got d=%b err=%b want d=011 err=0", out_data, step_err); end
      send(1'b0, 3'b110);
      checks++; if (out_data !== 3'd4 || step_err !== 1'b0 || err_count !== 8'd0) begin errors++; $display("FAIL dec_after_enc got d=%0d err=%b cnt=%0d want d=4 err=0 cnt=0", out_data, step_err, err_count); end
      send(1'b0, 3'b010);
      checks++; if (out_data !== 3'd3 || step_err !== 1'b0 || dir_up !== 1'b0) begin errors++; $display("FAIL dec_tracking got d=%0d err=%b up=%b want d=3 err=0 up=0", out_data, step_err, dir_up); end
   endtask

   task automatic test_backpressure();
      @(posedge clk); #1;
      out_ready = 1'b0; mode = 1'b0; in_valid = 1'b1; in_data = 3'b011;
      mon_q.delete();
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_data !== 3'd2 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_accept got v=%b d=%0d rdy=%b want v=1 d=2 rdy=0", out_valid, out_data, in_ready); end
      in_data = 3'b001;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         checks++; if (in_ready !== 1'b0 || out_data !== 3'd2 || out_valid !== 1'b1 || dir_up !== 1'b0 || step_err !== 1'b0) begin errors++; $display("FAIL bp_hold[%0d] got rdy=%b d=%0d v=%b up=%b err=%b want rdy=0 d=2 v=1 up=0 err=0", c, in_ready, out_data, out_valid, dir_up, step_err); end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++; if (out_data !== 3'd1 || out_valid !== 1'b1 || step_err !== 1'b0) begin errors++; $display("FAIL bp_release got d=%0d v=%b err=%b want d=1 v=1 err=0", out_data, out_valid, step_err); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got v=%b want 0", out_valid); end
      checks++; if (mon_q.size() != 2 || mon_q[0] !== 3'd2 || mon_q[1] !== 3'd1) begin errors++; $display("FAIL bp_transfers got n=%0d want n=2 seq 2,1", mon_q.size()); end
   endtask

   task automatic test_reset_midstream();
      send(1'b0, 3'b000);
      send(1'b0, 3'b011);
      checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL mid_err_count got %0d want 1", err_count); end
      out_ready = 1'b0;
      #2 reset = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0 || out_data !== 3'd0 || step_err !== 1'b0) begin errors++; $display("FAIL mid_reset_out got v=%b d=%0d err=%b want v=0 d=0 err=0", out_valid, out_data, step_err); end
      checks++; if (err_count !== 8'd0 || dir_up !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_state got cnt=%0d up=%b rdy=%b want cnt=0 up=1 rdy=1", err_count, dir_up, in_ready); end
      @(posedge clk); #1;
      reset = 1'b0; out_ready = 1'b1;
      send(1'b0, 3'b011);
      checks++; if (out_data !== 3'd2 || step_err !== 1'b0 || err_count !== 8'd0) begin errors++; $display("FAIL mid_nopred got d=%0d err=%b cnt=%0d want d=2 err=0 cnt=0", out_data, step_err, err_count); end
   endtask

   initial begin
      test_reset();
      test_decode_stream();
      test_wrap();
      test_step_error();
      test_encode();
      test_backpressure();
      test_reset_midstream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gray_stream_codec.md
GRAY_STREAM_CODEC -- requirements
Module: gray_stream_codec

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3, code word width in bits (legal range 2..16).
REQ-002 The block SHALL have parameter ERR_W, default 8, width of the step-error counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port mode, input, 1 bit: 0 = Gray-to-binary decode, 1 = binary-to-Gray encode.
REQ-006 The block SHALL have port in_valid, input, 1 bit: input word present.
REQ-007 The block SHALL have port in_ready, output, 1 bit: block can accept an input word.
REQ-008 The block SHALL have port in_data, input, WIDTH bits: input code word.
REQ-009 The block SHALL have port out_valid, output, 1 bit: output word present.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts the output word.
REQ-011 The block SHALL have port out_data, output, WIDTH bits: converted word.
REQ-012 The block SHALL have port step_err, output, 1 bit: the current output word was an illegal Gray step (decode mode only).
REQ-013 The block SHALL have port dir_up, output, 1 bit: direction of the last legal single-bit step (1 = increment).
REQ-014 The block SHALL have port err_count, output, ERR_W bits: saturating count of illegal steps.
REQ-015 The block SHALL have port clear_err, input, 1 bit: synchronous clear of err_count.

Function
REQ-016 An input transfer SHALL occur on a rising clk edge with in_valid=1 and in_ready=1; an output transfer SHALL occur with out_valid=1 and out_ready=1.
REQ-017 The block SHALL drive in_ready = !out_valid || out_ready, giving a single output register stage with full throughput.
REQ-018 The accepted word's result SHALL appear on out_data with out_valid=1 on the edge after acceptance (latency 1 cycle).
REQ-019 While out_valid=1 and out_ready=0, out_data, step_err and dir_up SHALL hold stable.
REQ-020 Decode mode SHALL compute b[W-1]=g[W-1] and b[i]=b[i+1] XOR g[i]; encode mode SHALL compute g = b XOR (b>>1).
REQ-021 Decode mode SHALL run a two-state tracker: NOPREV (no reference word) and TRACK (previous accepted Gray word and binary word stored).
REQ-022 In NOPREV, an accepted decode word SHALL give step_err=0, leave dir_up unchanged, store the word, and move the tracker to TRACK.
REQ-023 In TRACK, the step check SHALL be based on the Hamming distance between the new Gray word and the stored Gray word.
REQ-024 Distance 0 SHALL give step_err=0 and leave dir_up unchanged.
REQ-025 Distance 1 SHALL give step_err=0, with dir_up=1 if new_bin == prev_bin+1 mod 2^WIDTH and 0 otherwise; the 2^WIDTH-1 to 0 wrap SHALL count as up.
REQ-026 Distance 2 or more SHALL give step_err=1 and leave dir_up unchanged; the new word SHALL still be stored as the reference.
REQ-027 err_count SHALL increment on each accepted word flagged step_err=1 and SHALL saturate at all-ones.
REQ-028 When clear_err=1 coincides with an error increment, the clear SHALL take priority and err_count SHALL be 0.
REQ-029 Encode mode SHALL always give step_err=0 and SHALL force the tracker to NOPREV.
REQ-030 A change of mode SHALL apply to the next accepted word; the tracker SHALL restart from NOPREV.
REQ-031 A word already in the output register SHALL be unaffected by a change of mode.

Reset
REQ-032 reset SHALL immediately force the following, independent of clk: out_valid=0, out_data=0, step_err=0, dir_up=1, err_count=0, and tracker=NOPREV with stored words 0.
REQ-033 An output word pending when reset is asserted SHALL be discarded.
REQ-034 in_ready SHALL read 1 during reset and after reset deasserts.

Structure
REQ-035 The tracker state enumeration (NOPREV, TRACK) and the mode encodings SHALL live in the shared package gray_pkg.
REQ-036 The combinational Gray/binary conversion SHALL be a sub-module gray_conv, parametrised by WIDTH, with a mode input.
REQ-037 gray_conv SHALL be instantiated once for the datapath and once for the step check.

Verification (WIDTH=3)
REQ-038 Scenario 1: decode stream 000,001,011,010,110,111,101,100 with out_ready=1 -> out_data 0..7 one cycle after each input; step_err=0; dir_up=1.
REQ-039 Scenario 2: decode 100 followed by 000 (wrap) -> out_data 0, dir_up=1, step_err=0; then 100 -> out_data 7, dir_up=0.
REQ-040 Scenario 3: decode 000 then 011 -> second output is 2 with step_err=1 and err_count=1; with err_count preset to 255, a further error -> err_count stays 255.
REQ-041 Scenario 4: encode inputs 5 and 2 -> out_data 111 then 011; step_err=0.
REQ-042 Scenario 4 (continued): switch to decode, first word 110 -> step_err=0, tracker in TRACK.
REQ-043 Scenario 5: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 after the first acceptance and out_data stable; release -> no word lost or duplicated.
REQ-044 Scenario 6: assert reset mid-stream with out_valid=1 -> out_valid falls without waiting for clk and err_count=0; the next decode word is treated as NOPREV.
